// File: rtl/cpu_bus_arbiter_if.sv
// TileLink channel bundle shared by the core's masters and the interconnect port.
// Single-beat A request / D response, one transaction outstanding.
interface tilelink #(
  parameter int XLEN = 64,
  parameter int AW   = 64
);
  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [AW-1:0]     a_address;
  logic [XLEN-1:0]   a_data;
  logic [XLEN/8-1:0] a_mask;
  logic [2:0]        a_size;
  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [XLEN-1:0]   d_data;

  // Handshake: a beat transfers on a rising clk edge where valid && ready are both high;
  // valid may not depend on ready, and payload is meaningful only while valid is high.
  modport master (
    output a_valid, a_opcode, a_address, a_data, a_mask, a_size, d_ready,
    input  a_ready, d_valid, d_opcode, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_address, a_data, a_mask, a_size, d_ready,
    output a_ready, d_valid, d_opcode, d_data
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Merges the core's fetch and memory-access TileLink masters onto one downstream port,
// one A+D transaction per grant. Define ARB_RR_EN for round-robin instead of access-first priority.
module cpu_bus_arbiter #(
  parameter int XLEN = 64,
  parameter int AW   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_request,
  tilelink.slave     if_bus,
  input  logic       ma_request,
  tilelink.slave     ma_bus,
  tilelink.master    bus,
  output logic [1:0] owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    A_PHASE = 2'd1,
    D_PHASE = 2'd2
  } state_e;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_FETCH = 2'b01;
  localparam logic [1:0] OWN_MA    = 2'b10;

  state_e state_q, state_d;
  logic   owner_sel_q, owner_sel_d;
  logic [1:0] owner_q, owner_d;

  logic              own_a_valid;
  logic [2:0]        own_a_opcode;
  logic [AW-1:0]     own_a_address;
  logic [XLEN-1:0]   own_a_data;
  logic [XLEN/8-1:0] own_a_mask;
  logic [2:0]        own_a_size;
  logic              own_d_ready;

  logic in_a, in_d;
  logic a_hs, d_hs;
  logic req_any, win_sel;
  logic if_owns, ma_owns;

  // Owner-side view of the A channel and D ready, selected by the latched grant.
  always_comb begin
    own_a_valid   = owner_sel_q ? ma_bus.a_valid   : if_bus.a_valid;
    own_a_opcode  = owner_sel_q ? ma_bus.a_opcode  : if_bus.a_opcode;
    own_a_address = owner_sel_q ? ma_bus.a_address : if_bus.a_address;
    own_a_data    = owner_sel_q ? ma_bus.a_data    : if_bus.a_data;
    own_a_mask    = owner_sel_q ? ma_bus.a_mask    : if_bus.a_mask;
    own_a_size    = owner_sel_q ? ma_bus.a_size    : if_bus.a_size;
    own_d_ready   = owner_sel_q ? ma_bus.d_ready   : if_bus.d_ready;
  end

  assign in_a    = (state_q == A_PHASE);
  assign in_d    = (state_q == D_PHASE);
  assign a_hs    = in_a && own_a_valid && bus.a_ready;
  assign d_hs    = in_d && bus.d_valid && own_d_ready;
  assign req_any = if_request || ma_request;

`ifdef ARB_RR_EN
  logic last_sel_q;

  // On a tie the master that did not win last time goes first.
  assign win_sel = (if_request && ma_request) ? ~last_sel_q : ma_request;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sel_q <= 1'b0;
    end else if (state_q == IDLE && req_any) begin
      last_sel_q <= win_sel;
    end
  end
`else
  // A stalled memory access blocks the pipeline, so it beats instruction fetch.
  assign win_sel = ma_request;
`endif

  always_comb begin
    state_d     = state_q;
    owner_sel_d = owner_sel_q;
    owner_d     = owner_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d     = A_PHASE;
          owner_sel_d = win_sel;
          owner_d     = win_sel ? OWN_MA : OWN_FETCH;
        end
      end
      A_PHASE: begin
        if (a_hs) begin
          state_d = D_PHASE;
        end
      end
      D_PHASE: begin
        // Grant is released only here; a dropped request never aborts the transaction.
        if (d_hs) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_sel_q <= 1'b0;
      owner_q     <= OWN_NONE;
    end else begin
      state_q     <= state_d;
      owner_sel_q <= owner_sel_d;
      owner_q     <= owner_d;
    end
  end

  assign owner = owner_q;

  assign bus.a_valid   = in_a && own_a_valid;
  assign bus.a_opcode  = in_a ? own_a_opcode  : '0;
  assign bus.a_address = in_a ? own_a_address : '0;
  assign bus.a_data    = in_a ? own_a_data    : '0;
  assign bus.a_mask    = in_a ? own_a_mask    : '0;
  assign bus.a_size    = in_a ? own_a_size    : '0;
  assign bus.d_ready   = in_d && own_d_ready;

  assign if_owns = !owner_sel_q;
  assign ma_owns = owner_sel_q;

  // The non-owner sees a silent channel; D beats outside D_PHASE are never forwarded.
  assign if_bus.a_ready  = in_a && if_owns && bus.a_ready;
  assign if_bus.d_valid  = in_d && if_owns && bus.d_valid;
  assign if_bus.d_opcode = (in_d && if_owns) ? bus.d_opcode : '0;
  assign if_bus.d_data   = (in_d && if_owns) ? bus.d_data   : '0;

  assign ma_bus.a_ready  = in_a && ma_owns && bus.a_ready;
  assign ma_bus.d_valid  = in_d && ma_owns && bus.d_valid;
  assign ma_bus.d_opcode = (in_d && ma_owns) ? bus.d_opcode : '0;
  assign ma_bus.d_data   = (in_d && ma_owns) ? bus.d_data   : '0;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: reset, single grants, priority, stalls, late drop, mid-D reset.
module tb_cpu_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic       if_request;
  logic       ma_request;
  logic [1:0] owner;

  int n_chk  = 0;
  int n_fail = 0;

  tilelink #(.XLEN(64), .AW(64)) if_bus ();
  tilelink #(.XLEN(64), .AW(64)) ma_bus ();
  tilelink #(.XLEN(64), .AW(64)) bus ();

  cpu_bus_arbiter #(.XLEN(64), .AW(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_request (if_request),
    .if_bus     (if_bus),
    .ma_request (ma_request),
    .ma_bus     (ma_bus),
    .bus        (bus),
    .owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_all();
    if_request        = 1'b0;
    ma_request        = 1'b0;
    if_bus.a_valid    = 1'b0;
    if_bus.a_opcode   = '0;
    if_bus.a_address  = '0;
    if_bus.a_data     = '0;
    if_bus.a_mask     = '0;
    if_bus.a_size     = '0;
    if_bus.d_ready    = 1'b0;
    ma_bus.a_valid    = 1'b0;
    ma_bus.a_opcode   = '0;
    ma_bus.a_address  = '0;
    ma_bus.a_data     = '0;
    ma_bus.a_mask     = '0;
    ma_bus.a_size     = '0;
    ma_bus.d_ready    = 1'b0;
    bus.a_ready       = 1'b0;
    bus.d_valid       = 1'b0;
    bus.d_opcode      = '0;
    bus.d_data        = '0;
  endtask

  // Called in A_PHASE with downstream a_ready high: finishes the owner's transaction.
  task automatic complete(input bit sel, input logic [63:0] data);
    tick();
    if (sel) ma_bus.a_valid = 1'b0; else if_bus.a_valid = 1'b0;
    bus.d_valid  = 1'b1;
    bus.d_opcode = 3'd1;
    bus.d_data   = data;
    settle();
    chk("cpl_owner_d", {62'd0, owner}, sel ? 64'd2 : 64'd1);
    chk("cpl_d_data", sel ? ma_bus.d_data : if_bus.d_data, data);
    chk("cpl_other_d_valid", {63'd0, sel ? if_bus.d_valid : ma_bus.d_valid}, 64'd0);
    tick();
    if (sel) ma_request = 1'b0; else if_request = 1'b0;
    bus.d_valid = 1'b0;
    bus.d_data  = '0;
    settle();
    chk("cpl_owner_idle", {62'd0, owner}, 64'd0);
  endtask

  logic [1:0] first_code;
  logic [1:0] second_code;

  initial begin
    rst_n = 1'b0;
    clear_all();
    tick();
    tick();
    chk("rst_owner", {62'd0, owner}, 64'd0);
    chk("rst_bus_a_valid", {63'd0, bus.a_valid}, 64'd0);
    chk("rst_bus_d_ready", {63'd0, bus.d_ready}, 64'd0);
    chk("rst_if_a_ready", {63'd0, if_bus.a_ready}, 64'd0);
    chk("rst_ma_d_valid", {63'd0, ma_bus.d_valid}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Fetch only, zero-wait downstream.
    if_request       = 1'b1;
    if_bus.a_valid   = 1'b1;
    if_bus.a_opcode  = 3'd4;
    if_bus.a_address = 64'h8000_0000;
    if_bus.a_mask    = 8'h0f;
    if_bus.a_size    = 3'd2;
    if_bus.d_ready   = 1'b1;
    bus.a_ready      = 1'b1;
    settle();
    chk("f_idle_owner", {62'd0, owner}, 64'd0);
    chk("f_idle_a_valid", {63'd0, bus.a_valid}, 64'd0);
    tick();
    chk("f_a_owner", {62'd0, owner}, 64'd1);
    chk("f_a_valid", {63'd0, bus.a_valid}, 64'd1);
    chk("f_a_address", bus.a_address, 64'h8000_0000);
    chk("f_a_size", {61'd0, bus.a_size}, 64'd2);
    chk("f_if_a_ready", {63'd0, if_bus.a_ready}, 64'd1);
    chk("f_ma_a_ready", {63'd0, ma_bus.a_ready}, 64'd0);
    tick();
    if_bus.a_valid = 1'b0;
    bus.a_ready    = 1'b0;
    bus.d_valid    = 1'b1;
    bus.d_opcode   = 3'd1;
    bus.d_data     = 64'h0000_0013;
    settle();
    chk("f_d_owner", {62'd0, owner}, 64'd1);
    chk("f_if_d_valid", {63'd0, if_bus.d_valid}, 64'd1);
    chk("f_if_d_data", if_bus.d_data, 64'h13);
    chk("f_bus_d_ready", {63'd0, bus.d_ready}, 64'd1);
    chk("f_ma_d_valid", {63'd0, ma_bus.d_valid}, 64'd0);
    chk("f_ma_d_data", ma_bus.d_data, 64'd0);
    tick();
    if_request  = 1'b0;
    bus.d_valid = 1'b0;
    bus.d_data  = '0;
    settle();
    chk("f_end_owner", {62'd0, owner}, 64'd0);
    chk("f_end_if_d_valid", {63'd0, if_bus.d_valid}, 64'd0);

    // Simultaneous requests after a fetch: access wins in both arbitration modes.
    ma_request       = 1'b1;
    ma_bus.a_valid   = 1'b1;
    ma_bus.a_opcode  = 3'd0;
    ma_bus.a_address = 64'h1000;
    ma_bus.a_data    = 64'hdead;
    ma_bus.a_mask    = 8'hff;
    ma_bus.a_size    = 3'd3;
    ma_bus.d_ready   = 1'b1;
    if_request       = 1'b1;
    if_bus.a_valid   = 1'b1;
    if_bus.a_address = 64'h8000_0004;
    bus.a_ready      = 1'b1;
    tick();
    chk("b_a_owner", {62'd0, owner}, 64'd2);
    chk("b_a_address", bus.a_address, 64'h1000);
    chk("b_a_data", bus.a_data, 64'hdead);
    chk("b_ma_a_ready", {63'd0, ma_bus.a_ready}, 64'd1);
    chk("b_if_a_ready", {63'd0, if_bus.a_ready}, 64'd0);
    tick();
    ma_bus.a_valid = 1'b0;
    bus.a_ready    = 1'b0;
    bus.d_valid    = 1'b1;
    bus.d_data     = 64'haa;
    settle();
    chk("b_ma_d_valid", {63'd0, ma_bus.d_valid}, 64'd1);
    chk("b_ma_d_data", ma_bus.d_data, 64'haa);
    chk("b_if_d_valid", {63'd0, if_bus.d_valid}, 64'd0);
    chk("b_if_d_data", if_bus.d_data, 64'd0);
    tick();
    ma_request  = 1'b0;
    bus.d_valid = 1'b0;
    bus.d_data  = '0;
    bus.a_ready = 1'b1;
    settle();
    chk("b_bubble_owner", {62'd0, owner}, 64'd0);
    chk("b_bubble_if_a_ready", {63'd0, if_bus.a_ready}, 64'd0);
    chk("b_bubble_a_valid", {63'd0, bus.a_valid}, 64'd0);
    tick();
    chk("b_second_owner", {62'd0, owner}, 64'd1);
    chk("b_second_address", bus.a_address, 64'h8000_0004);
    complete(1'b0, 64'h77);

    // Access-only transaction, then a tie: round-robin favours fetch, fixed priority access.
    ma_request       = 1'b1;
    ma_bus.a_valid   = 1'b1;
    ma_bus.a_address = 64'h2000;
    bus.a_ready      = 1'b1;
    tick();
    chk("r_pre_owner", {62'd0, owner}, 64'd2);
    tick();
    ma_bus.a_valid = 1'b0;
    bus.d_valid    = 1'b1;
    bus.d_data     = 64'h1;
    tick();
    bus.d_valid      = 1'b0;
    ma_bus.a_valid   = 1'b1;
    ma_bus.a_address = 64'h2008;
    if_request       = 1'b1;
    if_bus.a_valid   = 1'b1;
    if_bus.a_address = 64'h8000_0008;
`ifdef ARB_RR_EN
    first_code  = 2'b01;
    second_code = 2'b10;
`else
    first_code  = 2'b10;
    second_code = 2'b01;
`endif
    tick();
    chk("r_first_owner", {62'd0, owner}, {62'd0, first_code});
    complete(first_code == 2'b10, 64'h1111);
    tick();
    chk("r_second_owner", {62'd0, owner}, {62'd0, second_code});
    complete(second_code == 2'b10, 64'h2222);

    // Downstream stalls A for 5 cycles, then delays D for 3; other master keeps requesting.
    ma_request       = 1'b1;
    ma_bus.a_valid   = 1'b1;
    ma_bus.a_address = 64'h3000;
    bus.a_ready      = 1'b0;
    tick();
    if_request       = 1'b1;
    if_bus.a_valid   = 1'b1;
    bus.d_valid      = 1'b1;
    bus.d_data       = 64'hbad;
    settle();
    for (int i = 0; i < 5; i++) begin
      chk("s_a_owner", {62'd0, owner}, 64'd2);
      chk("s_a_valid", {63'd0, bus.a_valid}, 64'd1);
      chk("s_ma_a_ready", {63'd0, ma_bus.a_ready}, 64'd0);
      chk("s_if_a_ready", {63'd0, if_bus.a_ready}, 64'd0);
      chk("s_early_d_ready", {63'd0, bus.d_ready}, 64'd0);
      chk("s_early_ma_d_valid", {63'd0, ma_bus.d_valid}, 64'd0);
      tick();
    end
    bus.a_ready = 1'b1;
    bus.d_valid = 1'b0;
    bus.d_data  = '0;
    settle();
    chk("s_ma_a_ready_go", {63'd0, ma_bus.a_ready}, 64'd1);
    tick();
    ma_bus.a_valid = 1'b0;
    bus.a_ready    = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("s_d_owner", {62'd0, owner}, 64'd2);
      chk("s_d_wait_valid", {63'd0, ma_bus.d_valid}, 64'd0);
      chk("s_d_ready", {63'd0, bus.d_ready}, 64'd1);
      chk("s_d_if_a_ready", {63'd0, if_bus.a_ready}, 64'd0);
      tick();
    end
    bus.d_valid = 1'b1;
    bus.d_data  = 64'h55;
    settle();
    chk("s_ma_d_valid", {63'd0, ma_bus.d_valid}, 64'd1);
    chk("s_ma_d_data", ma_bus.d_data, 64'h55);
    chk("s_if_d_valid", {63'd0, if_bus.d_valid}, 64'd0);
    tick();
    ma_request     = 1'b0;
    if_request     = 1'b0;
    if_bus.a_valid = 1'b0;
    bus.d_valid    = 1'b0;
    bus.d_data     = '0;
    settle();
    chk("s_end_owner", {62'd0, owner}, 64'd0);
    chk("s_end_ma_d_valid", {63'd0, ma_bus.d_valid}, 64'd0);

    // Fetch drops its request in D_PHASE; the transaction still completes.
    if_request       = 1'b1;
    if_bus.a_valid   = 1'b1;
    if_bus.a_address = 64'h8000_0010;
    bus.a_ready      = 1'b1;
    tick();
    chk("p_a_owner", {62'd0, owner}, 64'd1);
    tick();
    if_request     = 1'b0;
    if_bus.a_valid = 1'b0;
    bus.a_ready    = 1'b0;
    settle();
    chk("p_d_owner", {62'd0, owner}, 64'd1);
    chk("p_d_if_d_valid", {63'd0, if_bus.d_valid}, 64'd0);
    tick();
    chk("p_held_owner", {62'd0, owner}, 64'd1);
    bus.d_valid = 1'b1;
    bus.d_data  = 64'h99;
    settle();
    chk("p_if_d_data", if_bus.d_data, 64'h99);
    tick();
    bus.d_valid = 1'b0;
    bus.d_data  = '0;
    settle();
    chk("p_end_owner", {62'd0, owner}, 64'd0);

    // Reset asserted in D_PHASE drops the transaction at once.
    if_request       = 1'b1;
    if_bus.a_valid   = 1'b1;
    if_bus.a_address = 64'h8000_0020;
    bus.a_ready      = 1'b1;
    tick();
    tick();
    if_bus.a_valid = 1'b0;
    bus.a_ready    = 1'b0;
    settle();
    chk("x_d_owner", {62'd0, owner}, 64'd1);
    chk("x_d_ready", {63'd0, bus.d_ready}, 64'd1);
    rst_n       = 1'b0;
    bus.d_valid = 1'b1;
    bus.d_data  = 64'h66;
    settle();
    chk("x_rst_owner", {62'd0, owner}, 64'd0);
    chk("x_rst_d_ready", {63'd0, bus.d_ready}, 64'd0);
    chk("x_rst_if_d_valid", {63'd0, if_bus.d_valid}, 64'd0);
    chk("x_rst_if_d_data", if_bus.d_data, 64'd0);
    chk("x_rst_a_valid", {63'd0, bus.a_valid}, 64'd0);
    if_request = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("x_post_if_d_valid", {63'd0, if_bus.d_valid}, 64'd0);
    chk("x_post_owner", {62'd0, owner}, 64'd0);
    chk("x_post_d_ready", {63'd0, bus.d_ready}, 64'd0);
    bus.d_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
